// File: rtl/poli_crc_engine.sv
// -----------------------------------------------------------------------------
// poli_crc_engine
//
// Programmable CRC engine behind a request/acknowledge register bus.
// Software loads POLY and SEED, pulses INIT, and pushes input words into a
// small FIFO. The engine pops one word at a time and folds BITS_PER_CYCLE bits
// per clock into the CRC register, MSB first. There is no reflection and no
// final XOR. A one-cycle irq marks the point where the FIFO has drained and
// the engine has returned to idle with ENABLE set.
//
// Register map (byte offsets from CRC_BASE):
//   0x00 CONTROL  bit0 INIT (W1, self-clearing), bit1 CLR_ERR (W1,
//                 self-clearing), bit2 ENABLE (RW)
//   0x04 STATUS   bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 ADDR_ERR (sticky),
//                 bits[15:8] FIFO count (RO)
//   0x08 INPUT    push one word (WO, reads as 0)
//   0x0C OUTPUT   current CRC (RO)
//   0x10 POLY     polynomial (RW)
//   0x14 SEED     INIT value of the CRC (RW)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   bus_ren    read request, held until bus_ack
//   bus_wen    write request, held until bus_ack
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_rdata  read data, valid while bus_ack is high
//   bus_ack    one-cycle acknowledge, one cycle after a request is accepted
//   sel        upstream decode says the address is in the CRC window
//   irq        one-cycle done pulse
//
// Parameter constraints: 8 <= CRC_W <= DATA_W, BITS_PER_CYCLE divides DATA_W,
// FIFO_DEPTH is a power of two and at least 2.
// -----------------------------------------------------------------------------
module poli_crc_engine #(
    parameter int          DATA_W         = 32,
    parameter int          CRC_W          = 32,
    parameter int          BITS_PER_CYCLE = 8,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [31:0] CRC_BASE       = 32'h00FF0018,
    parameter logic [31:0] DEFAULT_POLY   = 32'h04C11DB7,
    parameter logic [31:0] DEFAULT_SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_ren,
    input  logic              bus_wen,
    input  logic [31:0]       bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    input  logic              sel,
    output logic              irq
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SLICES  = DATA_W / BITS_PER_CYCLE;
    localparam int SLICE_W = $clog2(SLICES + 1);

    localparam logic [31:0] A_CONTROL = CRC_BASE;
    localparam logic [31:0] A_STATUS  = CRC_BASE + 32'h04;
    localparam logic [31:0] A_INPUT   = CRC_BASE + 32'h08;
    localparam logic [31:0] A_OUTPUT  = CRC_BASE + 32'h0C;
    localparam logic [31:0] A_POLY    = CRC_BASE + 32'h10;
    localparam logic [31:0] A_SEED    = CRC_BASE + 32'h14;

    localparam logic [CRC_W-1:0] POLY_RESET = CRC_W'(DEFAULT_POLY);
    localparam logic [CRC_W-1:0] SEED_RESET = CRC_W'(DEFAULT_SEED);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state_reg;
    state_t               state_next;
    logic [CRC_W-1:0]     crc_reg;
    logic [CRC_W-1:0]     crc_next;
    logic [CRC_W-1:0]     poly_reg;
    logic [CRC_W-1:0]     seed_reg;
    logic [DATA_W-1:0]    sr_reg;
    logic [SLICE_W-1:0]   slice_cnt_reg;
    logic                 enable_reg;
    logic                 addr_err_reg;
    logic                 ack_reg;
    logic [DATA_W-1:0]    rdata_reg;
    logic                 irq_reg;

    logic [DATA_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     fifo_count_reg;

    // -------------------------------------------------------------------------
    // Address decode and request acceptance
    // -------------------------------------------------------------------------
    logic hit_control, hit_status, hit_input, hit_output, hit_poly, hit_seed;
    logic hit_any;
    logic req_valid;
    logic push_stall;
    logic accept;
    logic fifo_push, fifo_pop;
    logic fifo_full, fifo_empty;
    logic ctrl_wr, init_fire, clr_err;
    logic poly_wr, seed_wr;
    logic unmapped;
    logic load_en, shift_en;
    logic done_pulse;
    logic busy;
    logic fb_bit;
    logic [31:0]       status_word;
    logic [DATA_W-1:0] rd_value;

    assign hit_control = (bus_addr == A_CONTROL);
    assign hit_status  = (bus_addr == A_STATUS);
    assign hit_input   = (bus_addr == A_INPUT);
    assign hit_output  = (bus_addr == A_OUTPUT);
    assign hit_poly    = (bus_addr == A_POLY);
    assign hit_seed    = (bus_addr == A_SEED);
    assign hit_any     = hit_control | hit_status | hit_input |
                         hit_output  | hit_poly   | hit_seed;

    assign fifo_full  = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count_reg == '0);

    // Engine strobes depend on the state register only, which keeps the
    // acceptance path (which needs the pop) free of any combinational loop.
    assign load_en  = (state_reg == ST_LOAD);
    assign shift_en = (state_reg == ST_SHIFT);
    assign fifo_pop = load_en;

    // A request held across its own ack cycle must not be taken twice.
    assign req_valid = sel & (bus_ren | bus_wen) & ~ack_reg;

    // An INPUT write to a full FIFO waits, unless the engine frees the head
    // slot in this very cycle, in which case push and pop share the edge.
    assign push_stall = bus_wen & hit_input & fifo_full & ~fifo_pop;
    assign accept     = req_valid & ~push_stall;

    assign fifo_push = accept & bus_wen & hit_input;
    assign ctrl_wr   = accept & bus_wen & hit_control;
    assign init_fire = ctrl_wr & bus_wdata[0];
    assign clr_err   = ctrl_wr & bus_wdata[1];
    assign poly_wr   = accept & bus_wen & hit_poly;
    assign seed_wr   = accept & bus_wen & hit_seed;
    assign unmapped  = accept & ~hit_any;

    assign busy = (state_reg != ST_IDLE) | ~fifo_empty;

    always_comb begin
        status_word       = '0;
        status_word[0]    = busy;
        status_word[1]    = fifo_full;
        status_word[2]    = fifo_empty;
        status_word[3]    = addr_err_reg;
        status_word[15:8] = 8'(fifo_count_reg);
    end

    // Read mux; INPUT and unmapped offsets fall through to zero.
    always_comb begin
        rd_value = '0;
        if (hit_control) begin
            rd_value = DATA_W'({enable_reg, 2'b00});
        end else if (hit_status) begin
            rd_value = DATA_W'(status_word);
        end else if (hit_output) begin
            rd_value = DATA_W'(crc_reg);
        end else if (hit_poly) begin
            rd_value = DATA_W'(poly_reg);
        end else if (hit_seed) begin
            rd_value = DATA_W'(seed_reg);
        end
    end

    // -------------------------------------------------------------------------
    // Bus-side registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg      <= 1'b0;
            rdata_reg    <= '0;
            enable_reg   <= 1'b0;
            addr_err_reg <= 1'b0;
            poly_reg     <= POLY_RESET;
            seed_reg     <= SEED_RESET;
        end else begin
            ack_reg   <= accept;
            rdata_reg <= (accept & bus_ren) ? rd_value : '0;
            if (ctrl_wr) begin
                enable_reg <= bus_wdata[2];
            end
            if (unmapped) begin
                addr_err_reg <= 1'b1;
            end else if (clr_err) begin
                addr_err_reg <= 1'b0;
            end
            if (poly_wr) begin
                poly_reg <= bus_wdata[CRC_W-1:0];
            end
            if (seed_wr) begin
                seed_reg <= bus_wdata[CRC_W-1:0];
            end
        end
    end

    assign bus_ack   = ack_reg;
    assign bus_rdata = rdata_reg;

    // -------------------------------------------------------------------------
    // Input FIFO: storage array without reset, pointers with reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= bus_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else if (init_fire) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            fifo_count_reg <= fifo_count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // -------------------------------------------------------------------------
    // Engine FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            irq_reg   <= done_pulse;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_pulse = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable_reg && !fifo_empty) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Last slice of the word: chain straight into the next word
                // or park in IDLE (a cleared ENABLE also parks here).
                if (slice_cnt_reg == SLICE_W'(1)) begin
                    if (enable_reg && !fifo_empty) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        done_pulse = enable_reg & fifo_empty;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // INIT aborts whatever is in flight and never raises irq.
        if (init_fire) begin
            state_next = ST_IDLE;
            done_pulse = 1'b0;
        end
    end

    assign irq = irq_reg;

    // -------------------------------------------------------------------------
    // Engine datapath
    // -------------------------------------------------------------------------
    // Fold BITS_PER_CYCLE bits from the top of the shift register, MSB first.
    always_comb begin
        crc_next = crc_reg;
        fb_bit   = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            fb_bit   = crc_next[CRC_W-1] ^ sr_reg[DATA_W-1-i];
            crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb_bit ? poly_reg : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg       <= SEED_RESET;
            slice_cnt_reg <= '0;
        end else begin
            if (init_fire) begin
                crc_reg <= seed_reg;
            end else if (shift_en) begin
                crc_reg <= crc_next;
            end
            if (load_en) begin
                slice_cnt_reg <= SLICE_W'(SLICES);
            end else if (shift_en) begin
                slice_cnt_reg <= slice_cnt_reg - SLICE_W'(1);
            end
        end
    end

    // The shift register is the registered read port of the FIFO array, so
    // it carries no reset; it is always reloaded before it is consumed.
    always_ff @(posedge clk) begin
        if (load_en) begin
            sr_reg <= fifo_mem[rd_ptr_reg];
        end else if (shift_en) begin
            sr_reg <= sr_reg << BITS_PER_CYCLE;
        end
    end

endmodule

// File: tb/tb_poli_crc_engine.sv
// -----------------------------------------------------------------------------
// tb_poli_crc_engine
//
// Self-checking bench for poli_crc_engine at default parameters. Expected CRC
// values come from a bit-serial reference function that applies the CRC rule
// one input bit at a time over a whole word; random polynomials, seeds and
// words drive the main scenarios.
// -----------------------------------------------------------------------------
module tb_poli_crc_engine;

    localparam logic [31:0] BASE   = 32'h00FF0018;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_IN   = BASE + 32'h08;
    localparam logic [31:0] A_OUT  = BASE + 32'h0C;
    localparam logic [31:0] A_POLY = BASE + 32'h10;
    localparam logic [31:0] A_SEED = BASE + 32'h14;
    localparam logic [31:0] A_BAD  = BASE + 32'h18;
    localparam int          SLICES    = 4;
    localparam int          ACK_LIMIT = 16;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        bus_ren   = 1'b0;
    logic        bus_wen   = 1'b0;
    logic        sel       = 1'b0;
    logic [31:0] bus_addr  = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        irq;

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int irq_count    = 0;
    int last_irq_cyc = 0;
    int last_ack_cyc = 0;

    poli_crc_engine dut (
        .clk       (clk),
        .rst       (rst),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .sel       (sel),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count every cycle irq is high; a stuck irq shows up as count > 1.
    always @(negedge clk) begin
        if (irq === 1'b1) begin
            irq_count    = irq_count + 1;
            last_irq_cyc = cyc;
        end
    end

    // -------------------------------------------------------------------------
    // Reference model: the CRC rule applied bit by bit over one word
    // -------------------------------------------------------------------------
    function automatic logic [31:0] crc_word(input logic [31:0] crc_in,
                                             input logic [31:0] poly,
                                             input logic [31:0] word);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ word[i];
            c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Checking and bus tasks
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One bus transaction: hold the request until ack (bounded), then leave
    // one idle cycle before returning.
    task automatic xfer(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic use_sel, input int limit,
                        output logic [31:0] rdata, output int waited, output logic acked);
        bus_addr  = addr;
        bus_wdata = data;
        sel       = use_sel;
        bus_wen   = is_wr;
        bus_ren   = ~is_wr;
        waited    = 0;
        acked     = 1'b0;
        rdata     = '0;
        while (!acked && waited < limit) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus_ack === 1'b1) begin
                acked        = 1'b1;
                rdata        = bus_rdata;
                last_ack_cyc = cyc;
            end
        end
        bus_wen = 1'b0;
        bus_ren = 1'b0;
        sel     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [31:0] addr, input logic [31:0] data, output int waited);
        logic [31:0] d;
        logic        a;
        xfer(1'b1, addr, data, 1'b1, ACK_LIMIT, d, waited, a);
        check("wr_ack", {31'b0, a}, 32'h1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        int w;
        wr_w(addr, data, w);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        int   w;
        logic a;
        xfer(1'b0, addr, 32'h0, 1'b1, ACK_LIMIT, data, w, a);
        check("rd_ack", {31'b0, a}, 32'h1);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int          tries;
        st    = 32'h1;
        tries = 0;
        while (st[0] && tries < 64) begin
            rd(A_STAT, st);
            tries++;
        end
        check("idle_poll_busy", {31'b0, st[0]}, 32'h0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] d, p, s, word, model, cur_poly;
        int          w, max_w, in_ack;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, bus_ack}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(A_POLY, d); check("rst_poly", d, 32'h04C11DB7);
        rd(A_SEED, d); check("rst_seed", d, 32'hFFFFFFFF);
        rd(A_OUT, d);  check("rst_output", d, 32'hFFFFFFFF);
        rd(A_STAT, d); check("rst_status", d, 32'h00000004);
        rd(A_CTRL, d); check("rst_control", d, 32'h00000000);
        cur_poly = 32'h04C11DB7;

        // Single word 1 from seed 0 yields the polynomial; timing of irq
        wr(A_SEED, 32'h0);
        wr(A_CTRL, 32'h5);
        irq_count = 0;
        wr(A_IN, 32'h1);
        in_ack = last_ack_cyc;
        wait_idle();
        rd(A_OUT, d); check("one_word_crc", d, 32'h04C11DB7);
        check("one_word_irq_count", irq_count, 1);
        // push edge -> IDLE sees data, then LOAD + SLICES SHIFT cycles,
        // irq registered on the return to IDLE
        check("one_word_irq_latency", last_irq_cyc - in_ack, 2 + SLICES);

        // Seed 1 with word 0 also lands on the polynomial; seed 0, word 0 is 0
        wr(A_SEED, 32'h1);
        wr(A_CTRL, 32'h5);
        wr(A_IN, 32'h0);
        wait_idle();
        rd(A_OUT, d); check("seed1_word0", d, 32'h04C11DB7);
        wr(A_SEED, 32'h0);
        wr(A_CTRL, 32'h5);
        wr(A_IN, 32'h0);
        wait_idle();
        rd(A_OUT, d); check("seed0_word0", d, 32'h00000000);

        // Fill with ENABLE=0, then enable and keep pushing into a full FIFO
        for (int it = 0; it < 3; it++) begin
            p = $urandom;
            s = $urandom;
            wr(A_POLY, p);
            wr(A_SEED, s);
            wr(A_CTRL, 32'h1);
            cur_poly = p;
            rd(A_POLY, d); check("poly_rw", d, p);
            model = s;
            for (int k = 0; k < 4; k++) begin
                word = $urandom;
                wr_w(A_IN, word, w);
                check("fill_ack_latency", w, 1);
                model = crc_word(model, p, word);
            end
            rd(A_STAT, d); check("full_status", d, 32'h00000403);
            irq_count = 0;
            wr(A_CTRL, 32'h4);
            max_w = 0;
            for (int k = 0; k < 4; k++) begin
                word = $urandom;
                wr_w(A_IN, word, w);
                if (w > max_w) max_w = w;
                model = crc_word(model, p, word);
            end
            check("stall_seen", {31'b0, (max_w > 1)}, 32'h1);
            wait_idle();
            rd(A_OUT, d); check("stream_crc", d, model);
            check("stream_irq_count", irq_count, 1);
        end

        // INIT while shifting with three words queued
        s = $urandom;
        wr(A_SEED, s);
        wr(A_CTRL, 32'h1);
        for (int k = 0; k < 4; k++) wr(A_IN, $urandom);
        wr(A_CTRL, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        irq_count = 0;
        wr(A_CTRL, 32'h5);
        rd(A_STAT, d); check("init_abort_status", d, 32'h00000004);
        rd(A_OUT, d);  check("init_abort_output", d, s);
        repeat (10) @(posedge clk);
        #1;
        check("init_abort_no_irq", irq_count, 0);
        word = $urandom;
        wr(A_IN, word);
        wait_idle();
        model = crc_word(s, cur_poly, word);
        rd(A_OUT, d); check("after_init_crc", d, model);
        check("after_init_irq", irq_count, 1);

        // Unmapped offset, CLR_ERR, WO/RO handling, sel gating
        rd(A_BAD, d);  check("unmapped_rdata", d, 32'h0);
        rd(A_STAT, d); check("addr_err_set", d, 32'h0000000C);
        wr(A_CTRL, 32'h6);
        rd(A_STAT, d); check("addr_err_clr", d, 32'h00000004);
        rd(A_CTRL, d); check("control_readback", d, 32'h00000004);
        rd(A_IN, d);   check("input_reads_zero", d, 32'h0);
        wr(A_OUT, 32'h12345678);
        wr(A_STAT, 32'hFFFFFFFF);
        rd(A_OUT, d);  check("output_ro", d, model);
        rd(A_STAT, d); check("status_ro", d, 32'h00000004);
        begin
            logic [31:0] rdv;
            logic        a;
            xfer(1'b1, A_POLY, ~cur_poly, 1'b0, 4, rdv, w, a);
            check("nosel_no_ack", {31'b0, a}, 32'h0);
        end
        rd(A_POLY, d); check("nosel_poly_kept", d, cur_poly);

        // Reset in the middle of a run
        wr(A_CTRL, 32'h1);
        wr(A_IN, $urandom);
        wr(A_IN, $urandom);
        wr(A_CTRL, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_ack", {31'b0, bus_ack}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(A_POLY, d); check("midrst_poly", d, 32'h04C11DB7);
        rd(A_SEED, d); check("midrst_seed", d, 32'hFFFFFFFF);
        rd(A_OUT, d);  check("midrst_output", d, 32'hFFFFFFFF);
        rd(A_STAT, d); check("midrst_status", d, 32'h00000004);
        rd(A_CTRL, d); check("midrst_control", d, 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/poli_crc_engine.md
Name: poli_crc_engine

Overview:
- Parametrised successor to the fixed-function CRC peripheral in the POLI register window.
- Adds the following, all memory-mapped behind a simple request/acknowledge register bus at CRC_BASE:
  - programmable polynomial and seed
  - configurable CRC width
  - an input word FIFO with backpressure
  - a multi-bit-per-cycle engine
- Sits beside the NAND_NOR and XOR_BUF blocks and decodes only its own six registers.

Parameters:
- DATA_W, 32: bus data width and input word width.
- CRC_W, 32: CRC register width. Must satisfy 8 ≤ CRC_W ≤ DATA_W.
- BITS_PER_CYCLE, 8: input bits folded per clock. Must divide DATA_W.
- FIFO_DEPTH, 4: input FIFO entries. Must be a power of 2 and ≥ 2.
- CRC_BASE, 32'h00FF0018: byte address of the CONTROL register.
- DEFAULT_POLY, 32'h04C11DB7: POLY reset value, truncated to CRC_W.
- DEFAULT_SEED, 32'hFFFFFFFF: SEED reset value, truncated to CRC_W.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- bus_ren  in  1  read request, held until bus_ack.
- bus_wen  in  1  write request, held until bus_ack. Never asserted together with bus_ren.
- bus_addr  in  32  byte address.
- bus_wdata  in  DATA_W  write data.
- bus_rdata  out  DATA_W  read data, valid while bus_ack is high.
- bus_ack  out  1  one-cycle acknowledge.
- sel  in  1  address falls in the CRC window (upstream decode). The block acts on a request only when sel=1.
- irq  out  1  done pulse. High for 1 cycle when the FIFO drains and the engine goes idle with ENABLE=1.

Behaviour:
- Register map (offset from CRC_BASE):
  - 0x00 CONTROL: bit0 INIT (W1, self-clearing), bit1 CLR_ERR (W1, self-clearing), bit2 ENABLE (RW level).
  - 0x04 STATUS (RO): bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 ADDR_ERR (sticky), bits[15:8] FIFO count.
  - 0x08 INPUT (WO): push one word.
  - 0x0C OUTPUT (RO): current crc.
  - 0x10 POLY (RW).
  - 0x14 SEED (RW).
- Bus handshake:
  - Accepted request → bus_ack high exactly 1 cycle later; rdata is registered with that ack.
  - Next request is sampled no earlier than the cycle after ack.
  - Write to INPUT while FULL: ack is withheld until a slot frees. The push and the ack happen in the same cycle that space exists.
  - Read of a WO register returns 0.
  - Write to an RO register: ignored but acked.
  - Unmapped offset with sel=1: acked, rdata=0, ADDR_ERR set.
- Width rules:
  - POLY, SEED and crc hold CRC_W bits.
  - Writes take bus_wdata[CRC_W-1:0].
  - Reads zero-extend to DATA_W.
- Reset values:
  - bus_ack=0, bus_rdata=0, irq=0.
  - ENABLE=0, ADDR_ERR=0, FIFO empty.
  - POLY=DEFAULT_POLY, SEED=DEFAULT_SEED, crc=DEFAULT_SEED.
- Engine FSM:
  - States: IDLE, LOAD, SHIFT.
  - IDLE → LOAD when ENABLE=1 and FIFO not empty.
  - LOAD: pop FIFO head into shift register sr; cnt=DATA_W/BITS_PER_CYCLE.
  - SHIFT: each cycle processes BITS_PER_CYCLE bits of sr, MSB first. Per bit: fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0).
  - SHIFT exits when cnt reaches 0: → LOAD if the FIFO is not empty, else IDLE with an irq pulse.
  - No reflection and no final XOR.
- Latency: one word costs 1 + DATA_W/BITS_PER_CYCLE cycles (5 at defaults). Back-to-back words have no bubble beyond the LOAD cycle.
- BUSY = (state≠IDLE) | ~EMPTY.
- Clearing ENABLE mid-word: the engine finishes the current word, then holds in IDLE.
- INIT write:
  - Effective the cycle after its ack: FIFO flushed, FSM → IDLE, crc ← SEED.
  - Aborts any in-flight word with no irq.
  - ENABLE is updated from the same write's bit2.
- Simultaneous FIFO push (bus) and pop (LOAD) in the same cycle is legal; count is unchanged. A push while FULL coincident with a pop completes that cycle.
- POLY/SEED writes while BUSY take effect on the next bit processed / next INIT. Software must poll BUSY=0 before changing them.
- RST mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset, then read POLY, SEED, OUTPUT, STATUS → 0x04C11DB7, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000004 (EMPTY only).
- SEED=0, INIT|ENABLE, INPUT=0x00000001, poll BUSY=0 → OUTPUT=0x04C11DB7; irq pulsed once; 5 cycles from LOAD to IDLE.
- SEED=0x00000001, INIT|ENABLE, INPUT=0x00000000 → OUTPUT=0x04C11DB7. Then SEED=0, INIT, INPUT=0 → OUTPUT=0.
- ENABLE=0, write 5 INPUT words → first 4 acked next cycle, STATUS count=4 with FULL. The 5th is stalled until ENABLE=1 pops an entry, then acked; no word is lost, checked against a reference model.
- Write INIT while in SHIFT with 3 words queued → next cycle FSM=IDLE, count=0, OUTPUT=SEED, no irq.
- Read offset 0x18 → ack, rdata=0, ADDR_ERR=1. CLR_ERR write → ADDR_ERR=0.
